audio_mixer: RTL and testbench



---
 rtl/audio_mixer_pkg.sv | 28 ++
 rtl/audio_tick_gen.sv | 29 ++
 rtl/audio_mixer.sv | 179 +++++++++++++++++
 tb/tb_audio_mixer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and constants for the audio mixer stage.
package audio_mixer_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MIX_SSP,
        MIX_MB,
        MIX_SPK,
        SAT,
        OUT
    } state_t;

    localparam logic [3:0] UNITY_GAIN = 4'd8;
    localparam logic [3:0] MASTER_MAX = 4'd8;
    localparam int SRC_WIDTH   = 16;
    localparam int MB_SHIFT    = 5;
    localparam int SPK_SHIFT   = 13;
    localparam int GAIN_SHIFT  = $clog2(UNITY_GAIN);
    localparam int SCALED_W    = SRC_WIDTH + 4;

    // Q1.3 gain applied to a 16-bit source; result never exceeds SCALED_W bits
    function automatic logic [SCALED_W-1:0] scale(input logic [SRC_WIDTH-1:0] src,
                                                  input logic [3:0] gain);
        logic [SCALED_W-1:0] p;
        p = SCALED_W'(src) * SCALED_W'(gain);
        return p >> GAIN_SHIFT;
    endfunction
endpackage

// File: rtl/audio_tick_gen.sv
// Fractional sample-rate tick: phase accumulator yielding SAMPLE_RATE pulses per second of clk.
module audio_tick_gen #(
    parameter int CLOCK_SPEED_HZ = 27_000_000,
    parameter int SAMPLE_RATE    = 44100
)(
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    localparam int PW = $clog2(CLOCK_SPEED_HZ + SAMPLE_RATE) + 1;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_sum;

    assign phase_sum = phase + PW'(SAMPLE_RATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= '0;
            tick_o <= 1'b0;
        end else if (phase_sum >= PW'(CLOCK_SPEED_HZ)) begin
            phase  <= phase_sum - PW'(CLOCK_SPEED_HZ);
            tick_o <= 1'b1;
        end else begin
            phase  <= phase_sum;
            tick_o <= 1'b0;
        end
    end
endmodule

// File: rtl/audio_mixer.sv
// Per-tick mixer: gain-scaled sum of SSP/Mockingboard/speaker, master ramp, saturation, sticky clip.
// Optional AUDIO_MIXER_DCBLOCK_EN: DC-blocks the speaker path towards mid-scale.
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 27_000_000,
    parameter int SAMPLE_RATE    = 44100,
    parameter int ACC_WIDTH      = 20,
    parameter int RAMP_SAMPLES   = 64
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        speaker_i,
    input  logic [3:0]  gain_ssp_i,
    input  logic [3:0]  gain_mb_i,
    input  logic [3:0]  gain_spk_i,
    input  logic        mute_i,
    input  logic        clip_clr_i,
    output logic [15:0] audio_l_o,
    output logic [15:0] audio_r_o,
    output logic        valid_o,
    output logic        clip_o
);
    localparam int RW = $clog2(RAMP_SAMPLES + 1);
    localparam int PW = ACC_WIDTH + 4;

    state_t state, state_nxt;
    logic                 tick, pending;
    logic [15:0]          ssp_q;
    logic [9:0]           mb_l_q, mb_r_q;
    logic                 spk_q;
    logic [3:0]           g_ssp_q, g_mb_q, g_spk_q;
    logic [ACC_WIDTH-1:0] acc_l, acc_r;
    logic [3:0]           master;
    logic [RW-1:0]        ramp_cnt;
    logic [SRC_WIDTH-1:0] mb_l_al, mb_r_al, spk_al, spk_src;
    logic [PW-1:0]        prod_l, prod_r;
    logic                 ovf_l, ovf_r;
    logic [15:0]          sat_l, sat_r;

    audio_tick_gen #(
        .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ),
        .SAMPLE_RATE   (SAMPLE_RATE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign mb_l_al = SRC_WIDTH'(mb_l_q) << MB_SHIFT;
    assign mb_r_al = SRC_WIDTH'(mb_r_q) << MB_SHIFT;
    assign spk_al  = SRC_WIDTH'(spk_q) << SPK_SHIFT;

`ifdef AUDIO_MIXER_DCBLOCK_EN
    logic signed [15:0] dc;
    logic signed [17:0] dc_diff, spk_c;

    assign dc_diff = $signed({2'b00, spk_al}) - 18'(dc);
    assign spk_c   = dc_diff + 18'sh1000;

    always_comb begin
        spk_src = spk_c[15:0];
        if (spk_c < 18'sh0)         spk_src = 16'h0000;
        else if (spk_c > 18'sh2000) spk_src = 16'h2000;
    end

    // One leaky-integrator step per sample, taken as the speaker term is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                dc <= '0;
        else if (state == MIX_SPK) dc <= dc + 16'(dc_diff >>> 6);
    end
`else
    assign spk_src = spk_al;
`endif

    assign prod_l = (PW'(acc_l) * PW'(master)) >> GAIN_SHIFT;
    assign prod_r = (PW'(acc_r) * PW'(master)) >> GAIN_SHIFT;
    assign ovf_l  = prod_l > PW'(16'hFFFF);
    assign ovf_r  = prod_r > PW'(16'hFFFF);
    assign sat_l  = ovf_l ? 16'hFFFF : prod_l[15:0];
    assign sat_r  = ovf_r ? 16'hFFFF : prod_r[15:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick || pending) state_nxt = LOAD;
            LOAD:    state_nxt = MIX_SSP;
            MIX_SSP: state_nxt = MIX_MB;
            MIX_MB:  state_nxt = MIX_SPK;
            MIX_SPK: state_nxt = SAT;
            SAT:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            ssp_q     <= '0;
            mb_l_q    <= '0;
            mb_r_q    <= '0;
            spk_q     <= 1'b0;
            g_ssp_q   <= '0;
            g_mb_q    <= '0;
            g_spk_q   <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            master    <= '0;
            ramp_cnt  <= '0;
            audio_l_o <= '0;
            audio_r_o <= '0;
            valid_o   <= 1'b0;
            clip_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;

            if (state != IDLE && tick) pending <= 1'b1;
            else if (state == IDLE)    pending <= 1'b0;

            if (tick) begin
                if (ramp_cnt == RW'(RAMP_SAMPLES - 1)) begin
                    ramp_cnt <= '0;
                    if (mute_i) begin
                        if (master != 4'd0) master <= master - 4'd1;
                    end else if (master != MASTER_MAX) begin
                        master <= master + 4'd1;
                    end
                end else begin
                    ramp_cnt <= ramp_cnt + RW'(1);
                end
            end

            case (state)
                LOAD: begin
                    ssp_q   <= ssp_audio_i;
                    mb_l_q  <= mb_audio_l_i;
                    mb_r_q  <= mb_audio_r_i;
                    spk_q   <= speaker_i;
                    g_ssp_q <= gain_ssp_i;
                    g_mb_q  <= gain_mb_i;
                    g_spk_q <= gain_spk_i;
                    acc_l   <= '0;
                    acc_r   <= '0;
                end
                MIX_SSP: begin
                    acc_l <= acc_l + ACC_WIDTH'(scale(ssp_q, g_ssp_q));
                    acc_r <= acc_r + ACC_WIDTH'(scale(ssp_q, g_ssp_q));
                end
                MIX_MB: begin
                    acc_l <= acc_l + ACC_WIDTH'(scale(mb_l_al, g_mb_q));
                    acc_r <= acc_r + ACC_WIDTH'(scale(mb_r_al, g_mb_q));
                end
                MIX_SPK: begin
                    acc_l <= acc_l + ACC_WIDTH'(scale(spk_src, g_spk_q));
                    acc_r <= acc_r + ACC_WIDTH'(scale(spk_src, g_spk_q));
                end
                // Launched from SAT so the registered sample and valid_o appear during OUT
                SAT: begin
                    audio_l_o <= sat_l;
                    audio_r_o <= sat_r;
                    valid_o   <= 1'b1;
                end
                default: ;
            endcase

            if (state == SAT && (ovf_l || ovf_r)) clip_o <= 1'b1;
            else if (clip_clr_i)                  clip_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench: fast-tick instance for mixing/ramp/clip/reset, default instance for tick spacing.
module tb_audio_mixer;
    import audio_mixer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_slow_n;
    logic [15:0] ssp;
    logic [9:0]  mb_l, mb_r;
    logic        spk, mute, clip_clr;
    logic [3:0]  g_ssp, g_mb, g_spk;
    logic [15:0] audio_l, audio_r, s_l, s_r;
    logic        valid, clip, s_valid, s_clip;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit slow_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    audio_mixer #(.CLOCK_SPEED_HZ(700000), .SAMPLE_RATE(44100), .ACC_WIDTH(20), .RAMP_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ssp_audio_i(ssp), .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r),
        .speaker_i(spk), .gain_ssp_i(g_ssp), .gain_mb_i(g_mb), .gain_spk_i(g_spk),
        .mute_i(mute), .clip_clr_i(clip_clr), .audio_l_o(audio_l), .audio_r_o(audio_r),
        .valid_o(valid), .clip_o(clip)
    );

    audio_mixer dut_slow (
        .clk(clk), .rst_n(rst_slow_n), .ssp_audio_i(ssp), .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r),
        .speaker_i(spk), .gain_ssp_i(g_ssp), .gain_mb_i(g_mb), .gain_spk_i(g_spk),
        .mute_i(mute), .clip_clr_i(clip_clr), .audio_l_o(s_l), .audio_r_o(s_r),
        .valid_o(s_valid), .clip_o(s_clip)
    );

    typedef struct {
        logic [15:0] ssp;
        logic [9:0]  mbl, mbr;
        logic        spk;
        logic [3:0]  gs, gm, gk;
        logic [15:0] el, er;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout waiting for valid_o", name);
        end
    endtask

    task automatic set_in(input logic [15:0] s, input logic [9:0] l, input logic [9:0] r,
                          input logic k, input logic [3:0] gs, input logic [3:0] gm,
                          input logic [3:0] gk);
        ssp = s; mb_l = l; mb_r = r; spk = k; g_ssp = gs; g_mb = gm; g_spk = gk;
    endtask

    // Default-rate instance: tick spacing must be 612 or 613 cycles
    initial begin
        int last, d;
        bit ok;
        rst_slow_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_slow_n = 1'b1;
        last = 0;
        for (int k = 0; k < 7; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 1300; i++) begin
                @(negedge clk);
                if (s_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick_spacing: timeout waiting for valid_o");
                break;
            end
            if (k > 0) begin
                d = cyc - last;
                chk("tick_spacing_612_613", int'(d == 612 || d == 613), 1);
            end
            chk("slow_master0_out", int'(s_l) + int'(s_r) + int'(s_clip), 0);
            last = cyc;
        end
        slow_done = 1'b1;
    end

    initial begin
        int prev;
        int cnt;
        bit ok;
        vt[0] = '{16'h1000, 10'h100, 10'h100, 1'b1, 4'd8, 4'd8, 4'd8, 16'h5000, 16'h5000};
        vt[1] = '{16'h0000, 10'h3FF, 10'h000, 1'b0, 4'd8, 4'd8, 4'd8, 16'h7FE0, 16'h0000};
        vt[2] = '{16'h1234, 10'h000, 10'h000, 1'b0, 4'd4, 4'd8, 4'd8, 16'h091A, 16'h091A};
        vt[3] = '{16'h0000, 10'h001, 10'h200, 1'b0, 4'd8, 4'd15, 4'd8, 16'h003C, 16'h7800};
        vt[4] = '{16'h0000, 10'h000, 10'h000, 1'b1, 4'd8, 4'd8, 4'd15, 16'h3C00, 16'h3C00};
        vt[5] = '{16'hFFFF, 10'h3FF, 10'h3FF, 1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000};
        vt[6] = '{16'hFFFF, 10'h000, 10'h000, 1'b0, 4'd8, 4'd8, 4'd8, 16'hFFFF, 16'hFFFF};
        vt[7] = '{16'h0007, 10'h000, 10'h000, 1'b0, 4'd15, 4'd8, 4'd8, 16'h000D, 16'h000D};
        vt[8] = '{16'h1000, 10'h000, 10'h3FF, 1'b1, 4'd3, 4'd1, 4'd2, 16'h0E00, 16'h1DFC};

        rst_n = 1'b0;
        mute = 1'b0;
        clip_clr = 1'b0;
        set_in(16'h1000, 10'h100, 10'h100, 1'b1, 4'd8, 4'd8, 4'd8);
        repeat (3) @(negedge clk);
        chk("reset_l", audio_l, 0);
        chk("reset_r", audio_r, 0);
        chk("reset_valid", valid, 0);
        chk("reset_clip", clip, 0);
        rst_n = 1'b1;

        // Anti-pop ramp: sample n uses master = min(n/4, 8)
        for (int n = 1; n <= 36; n++) begin
            wait_valid("ramp");
            chk("ramp_l", audio_l, ((n / 4) > 8 ? 8 : n / 4) * 'hA00);
            chk("ramp_r", audio_r, ((n / 4) > 8 ? 8 : n / 4) * 'hA00);
            if (n == 1) begin
                @(negedge clk);
                chk("valid_one_cycle", valid, 0);
            end
        end

        for (int i = 0; i < 9; i++) begin
            set_in(vt[i].ssp, vt[i].mbl, vt[i].mbr, vt[i].spk, vt[i].gs, vt[i].gm, vt[i].gk);
            wait_valid("vec");
            wait_valid("vec");
            chk($sformatf("vec%0d_l", i), audio_l, vt[i].el);
            chk($sformatf("vec%0d_r", i), audio_r, vt[i].er);
            chk($sformatf("vec%0d_clip", i), clip, 0);
        end

        // Soft mute down and back up
        set_in(16'h1000, 10'h100, 10'h100, 1'b1, 4'd8, 4'd8, 4'd8);
        wait_valid("mute_pre");
        wait_valid("mute_pre");
        chk("mute_start", audio_l, 'h5000);
        prev = audio_l;
        mute = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_valid("mute");
            chk("mute_monotonic", int'(audio_l <= prev), 1);
            chk("mute_step", audio_l % 16'hA00, 0);
            prev = audio_l;
        end
        chk("mute_floor", audio_l, 0);
        mute = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_valid("unmute");
            chk("unmute_monotonic", int'(audio_l >= prev), 1);
            prev = audio_l;
        end
        chk("unmute_final", audio_l, 'h5000);

        // Saturation, sticky clip, clear
        set_in(16'hFFFF, 10'h3FF, 10'h3FF, 1'b1, 4'd15, 4'd15, 4'd15);
        wait_valid("sat");
        wait_valid("sat");
        chk("sat_l", audio_l, 'hFFFF);
        chk("sat_r", audio_r, 'hFFFF);
        chk("sat_clip", clip, 1);
        set_in(16'h0, 10'h0, 10'h0, 1'b0, 4'd8, 4'd8, 4'd8);
        wait_valid("sticky");
        wait_valid("sticky");
        chk("clip_sticky", clip, 1);
        @(negedge clk); clip_clr = 1'b1;
        @(negedge clk); clip_clr = 1'b0;
        chk("clip_cleared", clip, 0);
        wait_valid("clip_stay");
        chk("clip_stays_clear", clip, 0);

        // Set beats a simultaneous clear
        clip_clr = 1'b1;
        set_in(16'hFFFF, 10'h3FF, 10'h3FF, 1'b1, 4'd15, 4'd15, 4'd15);
        wait_valid("setwins");
        wait_valid("setwins");
        chk("clip_set_wins", clip, 1);
        @(negedge clk);
        chk("clip_clr_held", clip, 0);
        clip_clr = 1'b0;

        // Only the left channel overflows
        set_in(16'hFFFF, 10'h001, 10'h000, 1'b0, 4'd8, 4'd8, 4'd8);
        wait_valid("ovf_l");
        wait_valid("ovf_l");
        chk("ovf_l_out", audio_l, 'hFFFF);
        chk("ovf_r_out", audio_r, 'hFFFF);
        chk("ovf_l_clip", clip, 1);
        @(negedge clk); clip_clr = 1'b1;
        @(negedge clk); clip_clr = 1'b0;

        // Speaker held high
        set_in(16'h0, 10'h0, 10'h0, 1'b1, 4'd8, 4'd8, 4'd8);
`ifdef AUDIO_MIXER_DCBLOCK_EN
        for (int i = 0; i < 2000; i++) wait_valid("dc");
        chk("dc_converge_l", int'(audio_l >= 16'h0FC0 && audio_l <= 16'h1040), 1);
        chk("dc_converge_r", int'(audio_r >= 16'h0FC0 && audio_r <= 16'h1040), 1);
`else
        for (int i = 0; i < 3; i++) wait_valid("dc");
        chk("spk_steady_l", audio_l, 'h2000);
        chk("spk_steady_r", audio_r, 'h2000);
`endif

        // Async reset during MIX_MB
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.state == MIX_MB) begin
                ok = 1'b1;
                break;
            end
        end
        chk("found_mix_mb", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_l", audio_l, 0);
        chk("arst_r", audio_r, 0);
        chk("arst_valid", valid, 0);
        chk("arst_clip", clip, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        chk("no_partial_sample", cnt, 0);
        wait_valid("restart");
        chk("master_restart", audio_l, 0);

        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (slow_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("slow_instance_done", int'(ok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
